// File: rtl/seq_detect_param_if.sv
// Serial-stream bundle for seq_detect_param: qualified input bit, counter clear,
// and the detector's match/count/state observation outputs.
interface seq_detect_param_if #(
    parameter int CNT_W = 8,
    parameter int ST_W  = 3
);
    logic             en;
    logic             din;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic [ST_W-1:0]  state;

    modport master (
        output en, din, cnt_clr,
        input  match, match_cnt, state
    );

    modport slave (
        input  en, din, cnt_clr,
        output match, match_cnt, state
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: a prefix-length machine whose transition
// table is derived from PATTERN at elaboration, with Moore/Mealy output and a saturating match counter.
module seq_detect_param #(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b11011,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               MEALY   = 1'b0,
    parameter int               CNT_W   = 8,
    parameter int               ST_W    = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_param_if.slave bus
);
    typedef logic [ST_W-1:0] state_t;

    localparam state_t           FULL    = state_t'(PAT_W);
    localparam state_t           LAST    = state_t'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Bit i of the pattern in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(input int i);
        logic [PAT_W-1:0] sh;
        sh = PATTERN >> (PAT_W - 1 - i);
        return sh[0];
    endfunction

    // Longest pattern prefix, no longer than max_len, that is a suffix of the
    // first k pattern bits followed by b.
    function automatic int prefix_len(input int k, input logic b, input int max_len);
        int   best;
        int   j;
        logic ok;
        logic sb;
        best = 0;
        for (int len = 1; len <= max_len; len++) begin
            if (len <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < len; i++) begin
                    j  = k + 1 - len + i;
                    sb = (j == k) ? b : pat_bit(j);
                    if (sb != pat_bit(i)) ok = 1'b0;
                end
                if (ok) best = len;
            end
        end
        return best;
    endfunction

    // Mealy never parks in FULL, so an overlapping match resumes from the
    // longest proper border of the pattern itself.
    localparam state_t BORDER = state_t'(prefix_len(PAT_W - 1, PATTERN[0], PAT_W - 1));

    state_t           nxt_tab [PAT_W+1][2];
    state_t           state_q;
    state_t           step;
    logic             complete;
    logic             match_q;
    logic             mealy_match;
    logic [CNT_W-1:0] cnt_q;

    for (genvar k = 0; k <= PAT_W; k++) begin : g_next
        localparam state_t N0 = state_t'(prefix_len(k, 1'b0, PAT_W));
        localparam state_t N1 = state_t'(prefix_len(k, 1'b1, PAT_W));
        assign nxt_tab[k][0] = N0;
        assign nxt_tab[k][1] = N1;
    end

    always_comb begin
        step     = nxt_tab[state_q][bus.din];
        complete = 1'b0;
        if (MEALY) begin
            if (state_q == LAST && bus.din == PATTERN[0]) begin
                complete = 1'b1;
                step     = OVERLAP ? BORDER : '0;
            end
        end else begin
            if (state_q == FULL && !OVERLAP) step = nxt_tab[0][bus.din];
            complete = (step == FULL);
        end
    end

    // State, Moore match and counter only move on accepted bits; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (bus.en) begin
                state_q <= step;
                match_q <= complete && !MEALY;
            end
            if (bus.cnt_clr) begin
                cnt_q <= '0;
            end else if (bus.en && complete && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign mealy_match   = bus.en & complete & ~rst;
    assign bus.match     = MEALY ? mealy_match : match_q;
    assign bus.match_cnt = cnt_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Drives one shared serial stream into six detector configurations and compares
// each against a history-based reference model of the detection rules.
module tb_seq_detect_param;
    localparam int          NI       = 6;
    localparam int          PW   [NI] = '{5, 5, 5, 5, 4, 5};
    localparam logic [31:0] PAT  [NI] = '{32'h1B, 32'h1B, 32'h1B, 32'h1B, 32'hA, 32'h1B};
    localparam bit          OVL  [NI] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam bit          MLY  [NI] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam int          CMAX [NI] = '{255, 255, 255, 3, 255, 255};

    logic clk;
    logic rst;
    logic en;
    logic din;
    logic cnt_clr;

    seq_detect_param_if #(.CNT_W(8), .ST_W(3)) if_a ();
    seq_detect_param_if #(.CNT_W(8), .ST_W(3)) if_b ();
    seq_detect_param_if #(.CNT_W(8), .ST_W(3)) if_c ();
    seq_detect_param_if #(.CNT_W(2), .ST_W(3)) if_d ();
    seq_detect_param_if #(.CNT_W(8), .ST_W(3)) if_e ();
    seq_detect_param_if #(.CNT_W(8), .ST_W(3)) if_f ();

    assign {if_a.en, if_a.din, if_a.cnt_clr} = {en, din, cnt_clr};
    assign {if_b.en, if_b.din, if_b.cnt_clr} = {en, din, cnt_clr};
    assign {if_c.en, if_c.din, if_c.cnt_clr} = {en, din, cnt_clr};
    assign {if_d.en, if_d.din, if_d.cnt_clr} = {en, din, cnt_clr};
    assign {if_e.en, if_e.din, if_e.cnt_clr} = {en, din, cnt_clr};
    assign {if_f.en, if_f.din, if_f.cnt_clr} = {en, din, cnt_clr};

    seq_detect_param u_a (.clk(clk), .rst(rst), .bus(if_a));
    seq_detect_param #(.OVERLAP(1'b0)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    seq_detect_param #(.MEALY(1'b1)) u_c (.clk(clk), .rst(rst), .bus(if_c));
    seq_detect_param #(.CNT_W(2)) u_d (.clk(clk), .rst(rst), .bus(if_d));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010)) u_e (.clk(clk), .rst(rst), .bus(if_e));
    seq_detect_param #(.MEALY(1'b1), .OVERLAP(1'b0)) u_f (.clk(clk), .rst(rst), .bus(if_f));

    logic       obs_match [NI];
    logic [2:0] obs_state [NI];
    logic [7:0] obs_cnt   [NI];

    assign obs_match = '{if_a.match, if_b.match, if_c.match, if_d.match, if_e.match, if_f.match};
    assign obs_state = '{if_a.state, if_b.state, if_c.state, if_d.state, if_e.state, if_f.state};
    assign obs_cnt   = '{if_a.match_cnt, if_b.match_cnt, if_c.match_cnt,
                         {6'd0, if_d.match_cnt}, if_e.match_cnt, if_f.match_cnt};

    logic [63:0] hist    [NI];
    int          hlen    [NI];
    int          m_cnt   [NI];
    int          m_state [NI];
    logic        m_match [NI];
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] lowMask(input int k);
        return (64'd1 << k) - 64'd1;
    endfunction

    // Would accepting bit b make the last PW accepted bits equal the pattern?
    function automatic bit completes(input int i, input logic b);
        logic [63:0] h;
        h = {hist[i][62:0], b};
        return (hlen[i] + 1 >= PW[i]) && ((h & lowMask(PW[i])) == {32'd0, PAT[i]});
    endfunction

    function automatic int prefixLen(input int i, input int maxk);
        for (int k = maxk; k >= 1; k--) begin
            if (k <= hlen[i] && (hist[i] & lowMask(k)) == ({32'd0, PAT[i]} >> (PW[i] - k)))
                return k;
        end
        return 0;
    endfunction

    task automatic modelEdge(input logic r, input logic e, input logic d, input logic c);
        bit full;
        for (int i = 0; i < NI; i++) begin
            if (r) begin
                hist[i] = '0; hlen[i] = 0; m_cnt[i] = 0; m_state[i] = 0; m_match[i] = 1'b0;
            end else begin
                full = e && completes(i, d);
                if (e) begin
                    hist[i] = {hist[i][62:0], d};
                    if (hlen[i] < 64) hlen[i]++;
                    if (full) begin
                        m_state[i] = MLY[i] ? (OVL[i] ? prefixLen(i, PW[i] - 1) : 0) : PW[i];
                        if (!OVL[i]) begin
                            hist[i] = '0; hlen[i] = 0;
                        end
                    end else begin
                        m_state[i] = prefixLen(i, PW[i]);
                    end
                    m_match[i] = full && !MLY[i];
                end
                if (c) m_cnt[i] = 0;
                else if (full && m_cnt[i] < CMAX[i]) m_cnt[i]++;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic postEdgeChecks();
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("state[%0d]", i), obs_state[i], m_state[i]);
            checkOutput($sformatf("match_cnt[%0d]", i), obs_cnt[i], m_cnt[i]);
            if (!MLY[i]) checkOutput($sformatf("moore_match[%0d]", i), obs_match[i], m_match[i]);
        end
    endtask

    // One clock of stimulus: Mealy match is judged before the edge, the rest after it.
    task automatic applyStimulus(input logic r, input logic e, input logic d, input logic c);
        rst = r; en = e; din = d; cnt_clr = c;
        #2;
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("match_pre[%0d]", i), obs_match[i],
                        MLY[i] ? (e && !r && completes(i, d)) : m_match[i]);
        end
        @(posedge clk);
        #1;
        modelEdge(r, e, d, c);
        postEdgeChecks();
    endtask

    task automatic applyBits(input logic [31:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) applyStimulus(1'b0, 1'b1, bits[k], 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < NI; i++) begin
            hist[i] = '0; hlen[i] = 0; m_cnt[i] = 0; m_state[i] = 0; m_match[i] = 1'b0;
        end
        rst = 1'b1; en = 1'b0; din = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        modelEdge(1'b1, 1'b0, 1'b0, 1'b0);
        postEdgeChecks();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        applyBits(32'b11011011, 8);
        checkOutput("a_cnt_after_8", obs_cnt[0], 2);
        checkOutput("a_state_after_8", obs_state[0], 5);
        checkOutput("b_cnt_after_8", obs_cnt[1], 1);
        checkOutput("c_cnt_after_8", obs_cnt[2], 2);
        applyBits(32'b11011, 5);
        checkOutput("b_cnt_after_13", obs_cnt[1], 2);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyBits(32'b110, 3);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, k[0], 1'b0);
            checkOutput("a_state_stall", obs_state[0], 3);
        end
        applyBits(32'b11, 2);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b0, ~k[0], 1'b0);
            checkOutput("a_match_held", obs_match[0], 1);
        end
        checkOutput("a_cnt_after_stall", obs_cnt[0], 1);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyBits(32'b1101, 4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyBits(32'b1, 1);
        checkOutput("a_state_after_rst", obs_state[0], 1);
        checkOutput("a_cnt_after_rst", obs_cnt[0], 0);
        applyBits(32'b101, 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("a_cnt_clr_wins", obs_cnt[0], 0);
        checkOutput("a_match_on_clr", obs_match[0], 1);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyBits(32'b11011, 5);
        for (int k = 0; k < 9; k++) applyBits(32'b011, 3);
        checkOutput("d_cnt_saturated", obs_cnt[3], 3);
        checkOutput("a_cnt_ten", obs_cnt[0], 10);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyBits(32'b101010, 6);
        checkOutput("e_cnt_1010", obs_cnt[4], 2);

        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom % 64) == 0, ($urandom % 5) != 0,
                          1'($urandom), ($urandom % 32) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
